// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main control FSM (Moore); MULTICYCLE_CTRL_JALR_EN adds the JALR path.
// Latency: 3-5 cycles per instruction, plus one cycle per FETCH/MEMREAD/MEMWRITE wait on mem_ready_i.
// Backpressure: stalls in memory states until mem_ready_i; ready in any other state is ignored.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_update_o,
  output logic       branch_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MULTICYCLE_CTRL_JALR_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
`ifdef MULTICYCLE_CTRL_JALR_EN
    ,
    JALR1    = 4'd11,
    JALR2    = 4'd12
`endif
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t decode_tgt;
  logic   op_legal;

  always_comb begin
    op_legal   = 1'b1;
    decode_tgt = FETCH;
    case (op_i)
      OP_LW, OP_SW: decode_tgt = MEMADR;
      OP_R:         decode_tgt = EXECR;
      OP_I:         decode_tgt = EXECI;
      OP_BEQ:       decode_tgt = BEQ;
      OP_JAL:       decode_tgt = JAL;
`ifdef MULTICYCLE_CTRL_JALR_EN
      OP_JALR:      decode_tgt = JALR1;
`endif
      default:      op_legal   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
      DECODE:   state_d = decode_tgt;
      MEMADR:   state_d = (op_i == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = mem_ready_i ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready_i ? FETCH : MEMWRITE;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      JAL:      state_d = ALUWB;
`ifdef MULTICYCLE_CTRL_JALR_EN
      JALR1:    state_d = JALR2;
      JALR2:    state_d = ALUWB;
`endif
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Reset gates every enable combinationally so nothing fires while rst_ni is low,
  // even though the state register already sits in FETCH.
  always_comb begin
    mem_req_o    = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_update_o  = 1'b0;
    branch_o     = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    alu_op_o     = 2'b00;
    illegal_o    = 1'b0;
    if (!rst_ni) begin
      alu_src_b_o  = 2'b10;
      result_src_o = 2'b10;
    end else begin
      case (state_q)
        FETCH: begin
          mem_req_o    = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          ir_write_o   = mem_ready_i;
          pc_update_o  = mem_ready_i;
        end
        DECODE: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b01;
          illegal_o   = ~op_legal;
        end
        MEMADR: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
        end
        MEMREAD: begin
          mem_req_o = 1'b1;
          adr_src_o = 1'b1;
        end
        MEMWB: begin
          result_src_o = 2'b01;
          reg_write_o  = 1'b1;
        end
        MEMWRITE: begin
          mem_req_o   = 1'b1;
          adr_src_o   = 1'b1;
          mem_write_o = mem_ready_i;
        end
        EXECR: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        EXECI: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
          alu_op_o    = 2'b10;
        end
        ALUWB: reg_write_o = 1'b1;
        BEQ: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b01;
          branch_o    = 1'b1;
        end
        JAL: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          pc_update_o = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_JALR_EN
        JALR1: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
        end
        JALR2: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          pc_update_o = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 No parameters; all select widths fixed at 1 or 2 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 op_i  input  7  opcode field of the instruction register (instr[6:0]).
REQ-005 mem_ready_i  input  1  memory completes the current access this cycle.
REQ-006 mem_req_o  output  1  memory access request.
REQ-007 adr_src_o  output  1  address mux select: 0 PC, 1 ALUOut.
REQ-008 ir_write_o  output  1  instruction-register and OldPC load enable.
REQ-009 pc_update_o  output  1  unconditional PC write enable.
REQ-010 branch_o  output  1  conditional PC write, qualified by the ALU zero flag in the datapath.
REQ-011 mem_write_o  output  1  data-memory write enable.
REQ-012 reg_write_o  output  1  register-file write enable.
REQ-013 alu_src_a_o  output  2  4-way select: 00 PC, 01 OldPC, 10 rs1 (A), 11 unused.
REQ-014 alu_src_b_o  output  2  4-way select: 00 rs2 (B), 01 ImmExt, 10 constant 4, 11 unused.
REQ-015 result_src_o  output  2  4-way select: 00 ALUOut, 01 read data, 10 ALUResult, 11 unused.
REQ-016 alu_op_o  output  2  00 add, 01 subtract, 10 decode from funct fields.
REQ-017 illegal_o  output  1  one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-018 The block SHALL be a Moore FSM; outputs SHALL depend only on state and mem_ready_i, and any output not listed for a state SHALL be 0.
REQ-019 FETCH SHALL drive mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
REQ-020 FETCH SHALL assert ir_write and pc_update only when mem_ready_i=1, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-021 DECODE SHALL drive src_a=01, src_b=01, alu_op=00, then branch on op_i.
REQ-022 DECODE transitions SHALL be: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
REQ-023 Any other opcode in DECODE SHALL pulse illegal_o and go to FETCH.
REQ-024 MEMADR SHALL drive src_a=10, src_b=01, alu_op=00, then go to MEMREAD if op_i=0000011, else to MEMWRITE.
REQ-025 MEMREAD SHALL drive mem_req=1, adr_src=1, result_src=00, and go to MEMWB only when mem_ready_i=1.
REQ-026 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-027 MEMWRITE SHALL drive mem_req=1, adr_src=1, result_src=00, and mem_write=mem_ready_i, then go to FETCH when mem_ready_i=1.
REQ-028 EXECR SHALL drive src_a=10, src_b=00, alu_op=10, then go to ALUWB.
REQ-029 EXECI SHALL drive src_a=10, src_b=01, alu_op=10, then go to ALUWB.
REQ-030 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-031 BEQ SHALL drive src_a=10, src_b=00, alu_op=01, result_src=00, branch=1, then go to FETCH.
REQ-032 JAL SHALL drive src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1, then go to ALUWB.
REQ-033 Outside memory wait states, per-instruction cycle counts SHALL be: R/I-type 4, lw 5, sw 4, beq 3, jal 4.
REQ-034 A mem_ready_i pulse outside FETCH, MEMREAD, or MEMWRITE SHALL be ignored.
REQ-035 Unreachable state encodings SHALL recover to FETCH on the next edge.

Reset
REQ-036 rst_ni=0 SHALL force FETCH immediately, including mid-instruction or mid-wait.
REQ-037 While rst_ni=0, ir_write, pc_update, branch, mem_write, reg_write, mem_req, and illegal_o SHALL all be 0.
REQ-038 While rst_ni=0, the select outputs SHALL hold their FETCH values.
REQ-039 After rst_ni deasserts, the first FETCH access SHALL start on the next rising edge.

Configuration
REQ-040 With MULTICYCLE_CTRL_JALR_EN defined, op 1100111 in DECODE SHALL go to JALR1.
REQ-041 JALR1 SHALL drive src_a=10, src_b=01, alu_op=00, then go to JALR2.
REQ-042 JALR2 SHALL drive result_src=00, pc_update=1, src_a=01, src_b=10, alu_op=00, then go to ALUWB (jalr = 5 cycles).
REQ-043 Without MULTICYCLE_CTRL_JALR_EN, op 1100111 SHALL be illegal per REQ-023, and the JALR states SHALL not exist.

Verification
REQ-044 lw (op 0000011), mem_ready_i held 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5.
REQ-045 sw, mem_ready_i=0 for 3 cycles in MEMWRITE -> mem_write=0 during the wait, then 1 for exactly one cycle, then FETCH.
REQ-046 op 0000000 -> illegal_o=1 for exactly one cycle in DECODE, no write enables asserted, back in FETCH at cycle 3.
REQ-047 rst_ni pulled low during EXECR -> FETCH immediately with all enables 0; after release, ir_write=1 on the first ready cycle.
REQ-048 beq (op 1100011) -> branch=1, alu_op=01, src_a=10, src_b=00 in cycle 3, then FETCH.
REQ-049 op 1100111 -> with MULTICYCLE_CTRL_JALR_EN: JALR1, JALR2, ALUWB, pc_update=1 in JALR2; without it: illegal_o pulse.
